debounced_multi_counter: RTL and testbench
==========================================

// Module: debounced_multi_counter
// PURPOSE
//  N_CH-channel push-button event counter with a per-channel synchroniser, a debounce FSM and a CNT_W-bit counter.
//  Each clean rising edge of a button adds one to that channel's count.
//  Sits between board push-buttons and display/LED logic.
// PARAMETERS
//  N_CH          4        number of independent button channels
//  CNT_W         4        counter width per channel
//  DB_CYCLES     1000000  cycles the synchronised input must stay stable before it is accepted (>=2)
//  SATURATE      0        0: count wraps MAX->0; 1: count holds at 2**CNT_W-1
//  REPEAT_CYCLES 25000000 auto-repeat period in cycles (used only with HOLD_REPEAT_EN)
// PORTS
//  clock      in   1           system clock; all logic on the rising edge
//  reset      in   1           synchronous, active-high; clears all state
//  btn_in     in   N_CH        raw asynchronous button inputs, active-high
//  clear      in   1           synchronous clear of all counts only
//  stable_out out  N_CH        debounced level per channel
//  pulse_out  out  N_CH        1-cycle pulse per accepted count event
//  count_out  out  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (synchronous, active-high) zeroes the following:
//    - synchroniser flops, timers, stable_out, pulse_out and count_out;
//    - every FSM returns to LOW.
//  - Reset asserted mid-debounce or mid-repeat discards the pending event; no pulse.
//  - Synchroniser: 2 flops per channel (s1, s2); FSM acts on s2 only.
//  - Per-channel FSM; timer width $clog2(DB_CYCLES):
//      LOW : stable=0; s2=1 -> WAIT_H (timer=0)
//      WAIT_H : s2=0 -> LOW; else timer++; at timer==DB_CYCLES-1 -> HIGH, raise pulse
//      HIGH : stable=1; s2=0 -> WAIT_L (timer=0)
//      WAIT_L : s2=1 -> HIGH; else timer++; at timer==DB_CYCLES-1 -> LOW
//  - Any bounce inside WAIT_* aborts back to the previous stable state; the timer restarts on the next change.
//  - Latency: btn_in rising at edge t (held) gives the following:
//    - s2=1 after edge t+2;
//    - stable_out=1 and pulse_out=1 after edge t+2+DB_CYCLES;
//    - pulse_out falls on the next edge.
//  - Release (HIGH->LOW) produces no pulse.
//  - Counter updates on the same edge pulse_out is registered high; count_out lags pulse_out by 0 cycles (both registered together).
//  - Wrap: SATURATE=0, count 2**CNT_W-1 + event -> 0.
//  - Saturate: SATURATE=1 -> stays 2**CNT_W-1.
//  - clear=1: all counts -> 0 next edge, clear beats a simultaneous event.
//    The event's pulse_out still fires; the count is still 0.
//  - clear does not touch the FSMs, timers, stable_out or pulse_out.
//  - Channels are fully independent; simultaneous events on several channels each count once.
// CONFIGURATION
//  HOLD_REPEAT_EN defined: auto-repeat while held.
//    - While in HIGH, a repeat timer counts; the first repeat fires REPEAT_CYCLES cycles after entry to HIGH.
//    - Further repeats fire every REPEAT_CYCLES cycles; each one raises pulse_out for 1 cycle and counts +1.
//    - Leaving HIGH (entering WAIT_L) zeroes the repeat timer.
//    - The repeat timer keeps running during a WAIT_L that aborts back to HIGH? No: it restarts from 0.
//  HOLD_REPEAT_EN undefined: no repeat logic; exactly one pulse per press.
// TESTING (bench with DB_CYCLES=4, CNT_W=4, N_CH=4, REPEAT_CYCLES=10)
//  - Reset held 3 cycles then released: stable_out=0, pulse_out=0, count_out=0 on all channels.
//  - Clean press ch0 at edge t, held 20 cycles: pulse_out[0]=1 only at edge t+6, count ch0=1.
//    With HOLD_REPEAT_EN the count reaches 2 at t+16.
//  - Bounce ch1 1,0,1,0 (1 cycle each), then steady 1: exactly one pulse after steady 1 +6 cycles; count ch1=1.
//  - 16 clean presses ch2: SATURATE=0 gives count 0 after the 16th; SATURATE=1 gives 15.
//  - clear asserted on the same edge ch3's pulse fires (count was 5): pulse_out[3]=1, count ch3=0.
//  - Reset asserted at timer=2 in WAIT_H on ch0: no pulse ever for that press, FSM LOW, count 0.

Source files
------------

// File: rtl/debounced_multi_counter.sv
// debounced_multi_counter
//   N_CH-channel push-button event counter. Each channel has a 2-flop
//   synchroniser, a four-state debounce FSM and a CNT_W-bit event counter.
//   Every clean press (accepted LOW->HIGH transition) adds one to the count
//   of its channel.
//
//   Optional feature: define HOLD_REPEAT_EN to auto-repeat while a button is
//   held. The first repeat fires REPEAT_CYCLES cycles after entry to HIGH,
//   and further repeats follow every REPEAT_CYCLES cycles. Without the macro
//   each press produces exactly one event.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset of all state
//   btn_in     in   raw asynchronous buttons, active-high, one per channel
//   clear      in   synchronous clear of the counts only
//   stable_out out  debounced level per channel
//   pulse_out  out  1-cycle pulse per counted event
//   count_out  out  channel i count at [i*CNT_W +: CNT_W]
module debounced_multi_counter #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter bit          SATURATE      = 1'b0,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         btn_in,
  input  logic                    clear,
  output logic [N_CH-1:0]         stable_out,
  output logic [N_CH-1:0]         pulse_out,
  output logic [N_CH*CNT_W-1:0]   count_out
);

  typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;

  localparam int unsigned TW = $clog2(DB_CYCLES);
  // The timer compares its current value before incrementing, so the last
  // waiting cycle is at DB_CYCLES-2; the input is then seen stable for
  // exactly DB_CYCLES consecutive cycles (entry cycle included).
  localparam logic [TW-1:0]    TLAST = TW'(DB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  logic [N_CH-1:0]  s1_q, s2_q;
  logic [N_CH-1:0]  pulse_q, pulse_d;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [TW-1:0]    timer_q [N_CH];
  logic [TW-1:0]    timer_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RW    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]    rep_q [N_CH];
  logic [RW-1:0]    rep_d [N_CH];
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      pulse_d[i] = 1'b0;
      cnt_d[i]   = cnt_q[i];
`ifdef HOLD_REPEAT_EN
      rep_d[i]   = rep_q[i];
`endif
      case (state_q[i])
        LOW: begin
          if (s2_q[i]) begin
            state_d[i] = WAIT_H;
            timer_d[i] = '0;
          end
        end
        WAIT_H: begin
          if (!s2_q[i]) begin
            state_d[i] = LOW;
          end else if (timer_q[i] == TLAST) begin
            state_d[i] = HIGH;
            pulse_d[i] = 1'b1;
`ifdef HOLD_REPEAT_EN
            rep_d[i]   = '0;
`endif
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        HIGH: begin
          if (!s2_q[i]) begin
            state_d[i] = WAIT_L;
            timer_d[i] = '0;
`ifdef HOLD_REPEAT_EN
            rep_d[i]   = '0;
          end else if (rep_q[i] == RLAST) begin
            pulse_d[i] = 1'b1;
            rep_d[i]   = '0;
          end else begin
            rep_d[i]   = rep_q[i] + 1'b1;
`endif
          end
        end
        WAIT_L: begin
          if (s2_q[i]) begin
            // Bounce back to HIGH: the repeat period restarts from zero.
            state_d[i] = HIGH;
`ifdef HOLD_REPEAT_EN
            rep_d[i]   = '0;
`endif
          end else if (timer_q[i] == TLAST) begin
            state_d[i] = LOW;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        default: state_d[i] = LOW;
      endcase

      // clear wins over a simultaneous event; the pulse itself is unaffected.
      if (clear) begin
        cnt_d[i] = '0;
      end else if (pulse_d[i] && (!SATURATE || (cnt_q[i] != CMAX))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= LOW;
        timer_q[i] <= '0;
        cnt_q[i]   <= '0;
`ifdef HOLD_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef HOLD_REPEAT_EN
        rep_q[i]   <= rep_d[i];
`endif
      end
    end
  end

  always_comb begin
    stable_out = '0;
    count_out  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      stable_out[i]                 = (state_q[i] == HIGH) || (state_q[i] == WAIT_L);
      count_out[i*CNT_W +: CNT_W]   = cnt_q[i];
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: tb/tb_debounced_multi_counter.sv
module tb_debounced_multi_counter;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DB    = 4;
  localparam int unsigned REP   = 10;
  localparam bit          SAT   = 1'b0;
`ifdef HOLD_REPEAT_EN
  localparam bit          REP_EN = 1'b1;
`else
  localparam bit          REP_EN = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       btn_in = '0;
  logic                  clear = 1'b0;
  logic [N_CH-1:0]       stable_out;
  logic [N_CH-1:0]       pulse_out;
  logic [N_CH*CNT_W-1:0] count_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  debounced_multi_counter #(
    .N_CH(N_CH),
    .CNT_W(CNT_W),
    .DB_CYCLES(DB),
    .SATURATE(SAT),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_in(btn_in),
    .clear(clear),
    .stable_out(stable_out),
    .pulse_out(pulse_out),
    .count_out(count_out)
  );

  function automatic logic [CNT_W-1:0] cnt(input int unsigned ch);
    return count_out[ch*CNT_W +: CNT_W];
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset(input int unsigned n);
    reset  = 1'b1;
    btn_in = '0;
    clear  = 1'b0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // One full press on channel ch: pulse expected after the 6th edge.
  task automatic press(input int unsigned ch);
    btn_in[ch] = 1'b1;
    repeat (6) step();
    btn_in[ch] = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    do_reset(3);
    step();
    checks++;
    if (stable_out !== 4'b0000) begin
      errors++; $display("FAIL reset_stable got %b exp %b", stable_out, 4'b0000);
    end
    checks++;
    if (pulse_out !== 4'b0000) begin
      errors++; $display("FAIL reset_pulse got %b exp %b", pulse_out, 4'b0000);
    end
    checks++;
    if (count_out !== 16'h0000) begin
      errors++; $display("FAIL reset_count got %h exp %h", count_out, 16'h0000);
    end
  endtask

  task automatic test_press();
    logic [N_CH-1:0]  exp_p;
    logic [CNT_W-1:0] exp_c;
    logic             exp_s;
    do_reset(2);
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_p = ((k == 6) || (REP_EN && k == 16)) ? 4'b0001 : 4'b0000;
      exp_c = 4'(((k >= 6) ? 1 : 0) + ((REP_EN && k >= 16) ? 1 : 0));
      exp_s = (k >= 6);
      checks++;
      if (pulse_out !== exp_p) begin
        errors++; $display("FAIL press_pulse k=%0d got %b exp %b", k, pulse_out, exp_p);
      end
      checks++;
      if (cnt(0) !== exp_c) begin
        errors++; $display("FAIL press_count k=%0d got %0d exp %0d", k, cnt(0), exp_c);
      end
      checks++;
      if (stable_out[0] !== exp_s) begin
        errors++; $display("FAIL press_stable k=%0d got %b exp %b", k, stable_out[0], exp_s);
      end
    end
    btn_in[0] = 1'b0;
    exp_c = REP_EN ? 4'd2 : 4'd1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_s = (k < 6);
      checks++;
      if (pulse_out !== 4'b0000) begin
        errors++; $display("FAIL release_pulse k=%0d got %b exp %b", k, pulse_out, 4'b0000);
      end
      checks++;
      if (stable_out[0] !== exp_s) begin
        errors++; $display("FAIL release_stable k=%0d got %b exp %b", k, stable_out[0], exp_s);
      end
    end
    checks++;
    if (cnt(0) !== exp_c) begin
      errors++; $display("FAIL release_count got %0d exp %0d", cnt(0), exp_c);
    end
  endtask

  task automatic test_bounce();
    logic [N_CH-1:0] exp_p;
    do_reset(2);
    // 1,0,1,0 for one cycle each, then steady 1 from j=4.
    for (int j = 0; j < 16; j++) begin
      btn_in[1] = (j < 4) ? ((j % 2) == 0) : 1'b1;
      step();
      exp_p = (j + 1 == 10) ? 4'b0010 : 4'b0000;
      checks++;
      if (pulse_out !== exp_p) begin
        errors++; $display("FAIL bounce_pulse j=%0d got %b exp %b", j, pulse_out, exp_p);
      end
      checks++;
      if (stable_out[1] !== (j + 1 >= 10)) begin
        errors++; $display("FAIL bounce_stable j=%0d got %b exp %b", j, stable_out[1], (j + 1 >= 10));
      end
    end
    btn_in[1] = 1'b0;
    repeat (8) step();
    checks++;
    if (cnt(1) !== 4'd1) begin
      errors++; $display("FAIL bounce_count got %0d exp %0d", cnt(1), 4'd1);
    end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp_c;
    do_reset(2);
    for (int p = 1; p <= 16; p++) begin
      btn_in[2] = 1'b1;
      repeat (6) step();
      checks++;
      if (pulse_out !== 4'b0100) begin
        errors++; $display("FAIL wrap_pulse p=%0d got %b exp %b", p, pulse_out, 4'b0100);
      end
      exp_c = (SAT && p > 15) ? 4'd15 : 4'(p);
      checks++;
      if (cnt(2) !== exp_c) begin
        errors++; $display("FAIL wrap_count p=%0d got %0d exp %0d", p, cnt(2), exp_c);
      end
      btn_in[2] = 1'b0;
      repeat (8) step();
    end
  endtask

  task automatic test_clear();
    do_reset(2);
    for (int p = 0; p < 5; p++) press(3);
    checks++;
    if (cnt(3) !== 4'd5) begin
      errors++; $display("FAIL clear_pre_count got %0d exp %0d", cnt(3), 4'd5);
    end
    btn_in[3] = 1'b1;
    repeat (5) step();
    clear = 1'b1;
    step();
    checks++;
    if (pulse_out !== 4'b1000) begin
      errors++; $display("FAIL clear_pulse got %b exp %b", pulse_out, 4'b1000);
    end
    checks++;
    if (cnt(3) !== 4'd0) begin
      errors++; $display("FAIL clear_count got %0d exp %0d", cnt(3), 4'd0);
    end
    clear = 1'b0;
    step();
    checks++;
    if (stable_out !== 4'b1000) begin
      errors++; $display("FAIL clear_stable got %b exp %b", stable_out, 4'b1000);
    end
    checks++;
    if (count_out !== 16'h0000) begin
      errors++; $display("FAIL clear_after got %h exp %h", count_out, 16'h0000);
    end
    btn_in[3] = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    btn_in = 4'b0101;
    repeat (6) step();
    checks++;
    if (pulse_out !== 4'b0101) begin
      errors++; $display("FAIL simul_pulse got %b exp %b", pulse_out, 4'b0101);
    end
    checks++;
    if (count_out !== 16'h0101) begin
      errors++; $display("FAIL simul_count got %h exp %h", count_out, 16'h0101);
    end
    btn_in = 4'b0000;
    repeat (8) step();
    press(1);
    checks++;
    if (count_out !== 16'h0111) begin
      errors++; $display("FAIL simul_count2 got %h exp %h", count_out, 16'h0111);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (count_out !== 16'h0000) begin
      errors++; $display("FAIL idle_clear got %h exp %h", count_out, 16'h0000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    btn_in[0] = 1'b1;
    repeat (5) step();
    reset  = 1'b1;
    btn_in = '0;
    step();
    reset = 1'b0;
    checks++;
    if (pulse_out !== 4'b0000) begin
      errors++; $display("FAIL midrst_pulse got %b exp %b", pulse_out, 4'b0000);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ((pulse_out | stable_out) !== 4'b0000) begin
        errors++; $display("FAIL midrst_idle k=%0d got %b exp %b", k, pulse_out | stable_out, 4'b0000);
      end
    end
    checks++;
    if (count_out !== 16'h0000) begin
      errors++; $display("FAIL midrst_count got %h exp %h", count_out, 16'h0000);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_wrap();
    test_clear();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
